io_port_responder: RTL and testbench

//  I/O-side responder for the CPU's IOR/IOW instructions.
//  - Decodes the control unit's iom/wen strobes and the datapath address and write data.
//  - Bridges them to two buffered external streams (TX out, RX in) using valid/ready handshakes.
//  - Also provides a status register and a general-purpose output register.
//  - Sits beside data memory; its read data feeds the md=2'b10 register-file input mux.

---
 rtl/io_port_responder.sv | 157 +++++++++++++++
 tb/tb_io_port_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/io_port_responder.sv
// I/O-space responder for IOR/IOW: TX/RX stream FIFOs, sticky status flags and a GPIO register.
// CPU reads are combinational and side effects commit on the following rising edge.
module io_port_responder #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iom_in,
    input  logic          wen_in,
    input  logic [15:0]   addr_in,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [DW-1:0] gpio_out
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] ADDR_TXD  = 2'd0;
    localparam logic [1:0] ADDR_RXD  = 2'd1;
    localparam logic [1:0] ADDR_STAT = 2'd2;
    localparam logic [1:0] ADDR_GPIO = 2'd3;

    logic [DW-1:0] r_tx_mem [DEPTH];
    logic [AW-1:0] r_tx_rd_ptr;
    logic [AW-1:0] r_tx_wr_ptr;
    logic [CW-1:0] r_tx_cnt;

    logic [DW-1:0] r_rx_mem [DEPTH];
    logic [AW-1:0] r_rx_rd_ptr;
    logic [AW-1:0] r_rx_wr_ptr;
    logic [CW-1:0] r_rx_cnt;

    logic          r_tx_ovf;
    logic          r_rx_unf;
    logic [DW-1:0] r_gpio;

    logic          w_wr;
    logic          w_rd;
    logic [1:0]    w_addr;
    logic          w_unused_addr;
    logic          w_tx_empty;
    logic          w_tx_full;
    logic          w_rx_empty;
    logic          w_rx_full;
    logic          w_tx_pop;
    logic          w_tx_push_req;
    logic          w_tx_push;
    logic          w_tx_drop;
    logic          w_rx_push;
    logic          w_rx_rd;
    logic          w_rx_pop;
    logic          w_rx_unf_set;
    logic          w_stat_wr;
    logic [DW-1:0] w_stat;

    assign w_wr          = iom_in & ~wen_in;
    assign w_rd          = iom_in & wen_in;
    assign w_addr        = addr_in[1:0];
    assign w_unused_addr = ^addr_in[15:2];

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == FULL_CNT);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == FULL_CNT);

    assign tx_valid = ~w_tx_empty;
    assign tx_data  = w_tx_empty ? '0 : r_tx_mem[r_tx_rd_ptr];
    assign rx_ready = ~w_rx_full;
    assign gpio_out = r_gpio;

    // A push into a full TX FIFO still lands when the head leaves on the same edge.
    assign w_tx_pop      = tx_valid & tx_ready;
    assign w_tx_push_req = w_wr & (w_addr == ADDR_TXD);
    assign w_tx_push     = w_tx_push_req & (~w_tx_full | w_tx_pop);
    assign w_tx_drop     = w_tx_push_req & ~w_tx_push;

    assign w_rx_push    = rx_valid & rx_ready;
    assign w_rx_rd      = w_rd & (w_addr == ADDR_RXD);
    assign w_rx_pop     = w_rx_rd & ~w_rx_empty;
    assign w_rx_unf_set = w_rx_rd & w_rx_empty;

    assign w_stat_wr = w_wr & (w_addr == ADDR_STAT);
    assign w_stat    = DW'({r_rx_unf, r_tx_ovf, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full});

    always_comb begin
        data_out = '0;
        if (w_rd) begin
            unique case (w_addr)
                ADDR_TXD:  data_out = '0;
                ADDR_RXD:  data_out = w_rx_empty ? '0 : r_rx_mem[r_rx_rd_ptr];
                ADDR_STAT: data_out = w_stat;
                ADDR_GPIO: data_out = r_gpio;
                default:   data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= data_in;
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_rd_ptr <= '0;
            r_tx_wr_ptr <= '0;
            r_tx_cnt    <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_wr_ptr <= '0;
            r_rx_cnt    <= '0;
        end else begin
            if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + AW'(1);
            if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + AW'(1);
            r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
            if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + AW'(1);
            if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + AW'(1);
            r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
        end
    end

    // Sticky flags: a fresh set event beats a W1C clear on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_ovf <= 1'b0;
            r_rx_unf <= 1'b0;
            r_gpio   <= '0;
        end else begin
            if (w_tx_drop) begin
                r_tx_ovf <= 1'b1;
            end else if (w_stat_wr & data_in[4]) begin
                r_tx_ovf <= 1'b0;
            end
            if (w_rx_unf_set) begin
                r_rx_unf <= 1'b1;
            end else if (w_stat_wr & data_in[5]) begin
                r_rx_unf <= 1'b0;
            end
            if (w_wr & (w_addr == ADDR_GPIO)) begin
                r_gpio <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: reset, TX fill/drain/overflow, RX underflow/full, GPIO.
module tb_io_port_responder;

    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst;
    logic          iom_in;
    logic          wen_in;
    logic [15:0]   addr_in;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [DW-1:0] gpio_out;

    int n_tests;
    int n_fail;
    logic [DW-1:0] rdata;

    io_port_responder #(.DW(DW), .DEPTH(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .iom_in   (iom_in),
        .wen_in   (wen_in),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .data_out (data_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .gpio_out (gpio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        iom_in  = 1'b0;
        wen_in  = 1'b1;
        addr_in = '0;
        data_in = '0;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [DW-1:0] d);
        iom_in  = 1'b1;
        wen_in  = 1'b0;
        addr_in = {14'b0, a};
        data_in = d;
        step();
        bus_idle();
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [DW-1:0] d);
        iom_in  = 1'b1;
        wen_in  = 1'b1;
        addr_in = {14'b0, a};
        #1;
        d = data_out;
        step();
        bus_idle();
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        bus_idle();
        repeat (3) step();
        rst = 1'b0;
        step();

        // 1: reset asserted mid-stream
        cpu_write(2'd3, 16'h1234);
        cpu_write(2'd0, 16'h0077);
        rx_valid = 1'b1;
        rx_data  = 16'h0033;
        step();
        rx_valid = 1'b0;
        check_eq("pre_rst_tx_valid", {15'b0, tx_valid}, 16'h0001);
        rst = 1'b1;
        #1;
        check_eq("rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
        check_eq("rst_tx_data", tx_data, 16'h0000);
        check_eq("rst_rx_ready", {15'b0, rx_ready}, 16'h0001);
        check_eq("rst_gpio", gpio_out, 16'h0000);
        step();
        rst = 1'b0;
        check_eq("idle_data_out", data_out, 16'h0000);
        cpu_read(2'd2, rdata);
        check_eq("rst_stat", rdata, 16'h000A);
        cpu_read(2'd1, rdata);
        check_eq("rst_rx_discarded", rdata, 16'h0000);
        cpu_write(2'd2, 16'h0020);

        // 2: TX fill, overflow, drain
        for (int i = 1; i <= 4; i++) cpu_write(2'd0, DW'(i));
        check_eq("tx_head", tx_data, 16'h0001);
        cpu_write(2'd0, 16'h0005);
        cpu_read(2'd2, rdata);
        check_eq("tx_full_ovf_stat", rdata, 16'h0019);
        cpu_write(2'd2, 16'h0010);
        cpu_read(2'd2, rdata);
        check_eq("tx_ovf_w1c", rdata, 16'h0009);
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_eq("tx_drain_valid", {15'b0, tx_valid}, 16'h0001);
            check_eq("tx_drain_data", tx_data, DW'(i));
            step();
        end
        check_eq("tx_drained", {15'b0, tx_valid}, 16'h0000);
        tx_ready = 1'b0;

        // 3: push and pop on the same edge while full
        for (int i = 11; i <= 14; i++) cpu_write(2'd0, DW'(i));
        tx_ready = 1'b1;
        cpu_write(2'd0, 16'h0009);
        tx_ready = 1'b0;
        cpu_read(2'd2, rdata);
        check_eq("tx_pushpop_stat", rdata, 16'h0009);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("tx_pushpop_data", tx_data, (i == 3) ? 16'h0009 : DW'(12 + i));
            step();
        end
        check_eq("tx_pushpop_empty", {15'b0, tx_valid}, 16'h0000);
        tx_ready = 1'b0;

        // 4: RX underflow, ordering, W1C
        cpu_read(2'd1, rdata);
        check_eq("rx_unf_data", rdata, 16'h0000);
        cpu_read(2'd2, rdata);
        check_eq("rx_unf_stat", rdata, 16'h002A);
        rx_valid = 1'b1;
        rx_data  = 16'h00A5;
        step();
        rx_data  = 16'h005A;
        step();
        rx_valid = 1'b0;
        cpu_read(2'd1, rdata);
        check_eq("rx_first", rdata, 16'h00A5);
        cpu_read(2'd1, rdata);
        check_eq("rx_second", rdata, 16'h005A);
        cpu_write(2'd2, 16'h0020);
        cpu_read(2'd2, rdata);
        check_eq("rx_unf_w1c", rdata, 16'h000A);

        // 5: RX full boundary with rx_valid held
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = DW'(16'h0011 + i);
            step();
        end
        rx_data = 16'h0099;
        check_eq("rx_full_ready", {15'b0, rx_ready}, 16'h0000);
        step();
        check_eq("rx_full_hold", {15'b0, rx_ready}, 16'h0000);
        cpu_read(2'd2, rdata);
        check_eq("rx_full_stat", rdata, 16'h0006);
        cpu_read(2'd1, rdata);
        check_eq("rx_full_read", rdata, 16'h0011);
        check_eq("rx_ready_after_pop", {15'b0, rx_ready}, 16'h0001);
        rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_read(2'd1, rdata);
            check_eq("rx_full_drain", rdata, DW'(16'h0012 + i));
        end
        cpu_read(2'd2, rdata);
        check_eq("rx_drained_stat", rdata, 16'h000A);

        // 6: GPIO and strobe decode
        iom_in  = 1'b0;
        wen_in  = 1'b0;
        addr_in = 16'h0003;
        data_in = 16'h1111;
        step();
        bus_idle();
        check_eq("gpio_no_iom", gpio_out, 16'h0000);
        cpu_write(2'd3, 16'hBEEF);
        check_eq("gpio_write", gpio_out, 16'hBEEF);
        cpu_read(2'd3, rdata);
        check_eq("gpio_read", rdata, 16'hBEEF);
        iom_in  = 1'b0;
        wen_in  = 1'b1;
        addr_in = 16'h0003;
        #1;
        check_eq("no_rd_data_out", data_out, 16'h0000);
        bus_idle();
        cpu_read(2'd0, rdata);
        check_eq("txd_read_zero", rdata, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
